// File: rtl/apb_des_pkg.sv
// Shared types and constants for the DES block APB requester.
package apb_des_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_LO = 4'h0;
    localparam logic [3:0] ADDR_HI = 4'h1;

    typedef logic [63:0] block_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable down-counter bounding ACCESS-phase wait states; expire_c flags the last allowed wait cycle.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic load,
    input  logic tick,
    output logic expire_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT);
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Expires on the TIMEOUT-th consecutive not-ready ACCESS cycle.
    assign expire_c = tick && (cnt == CW'(1));

endmodule

// File: rtl/apb_des_block_master.sv
// APB3 requester moving one 64-bit DES block as two 32-bit transfers (low word first).
// Optional write read-back check enabled by defining APB_DES_MASTER_VERIFY_EN.
module apb_des_block_master
    import apb_des_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [11:0] BASE_ADDR = 12'h000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        start,
    input  logic        wr,
    input  block_t      wdata,
    output block_t      rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [11:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [11:0] ADDR_W0 = {BASE_ADDR[11:4], ADDR_LO};
    localparam logic [11:0] ADDR_W1 = {BASE_ADDR[11:4], ADDR_HI};

    state_t      state;
    logic        widx;
    logic [31:0] wdata_hi;
    logic        expire_c;
    logic        xfer_ok_c;
    logic        slverr_c;
    logic        more_c;
    logic        end_c;

`ifdef APB_DES_MASTER_VERIFY_EN
    block_t      wdata_q;
    logic        vphase;
    logic        miscmp_c;

    assign wdata_hi = wdata_q[63:32];
    // A finished write phase is followed by the read-back phase.
    assign more_c   = !widx || PWRITE;
    assign miscmp_c = vphase && (PRDATA != (widx ? wdata_q[63:32] : wdata_q[31:0]));
`else
    logic [31:0] wdata_q;

    assign wdata_hi = wdata_q;
    assign more_c   = !widx;
`endif

    assign xfer_ok_c = (state == ACCESS) && PREADY && !PSLVERR;
    assign slverr_c  = (state == ACCESS) && PREADY && PSLVERR;
    assign end_c     = slverr_c || expire_c || (xfer_ok_c && !more_c);

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .load     (state == SETUP),
        .tick     ((state == ACCESS) && !PREADY),
        .expire_c (expire_c)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            widx    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
`ifdef APB_DES_MASTER_VERIFY_EN
            vphase  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef APB_DES_MASTER_VERIFY_EN
                        wdata_q <= wdata;
                        vphase  <= 1'b0;
`else
                        wdata_q <= wdata[63:32];
`endif
                        widx    <= 1'b0;
                        err     <= 1'b0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= wr;
                        PADDR   <= ADDR_W0;
                        PWDATA  <= wr ? wdata[31:0] : 32'h0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (xfer_ok_c && !PWRITE) begin
                        if (widx) rdata[63:32] <= PRDATA;
                        else      rdata[31:0]  <= PRDATA;
                    end
`ifdef APB_DES_MASTER_VERIFY_EN
                    if (xfer_ok_c && miscmp_c) err <= 1'b1;
`endif
                    if (slverr_c || expire_c) err     <= 1'b1;
                    if (expire_c)             timeout <= 1'b1;

                    if (end_c) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b0;
                        PADDR   <= '0;
                        PWDATA  <= '0;
                    end else if (xfer_ok_c) begin
                        // Back-to-back: PSEL stays high, next SETUP follows directly.
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                        if (!widx) begin
                            widx   <= 1'b1;
                            PADDR  <= ADDR_W1;
                            PWDATA <= PWRITE ? wdata_hi : 32'h0;
                        end
`ifdef APB_DES_MASTER_VERIFY_EN
                        else begin
                            widx   <= 1'b0;
                            vphase <= 1'b1;
                            PWRITE <= 1'b0;
                            PADDR  <= ADDR_W0;
                            PWDATA <= 32'h0;
                        end
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
